// File: rtl/gng_lzd_arb.sv
// Round-robin shared 48-bit leading-zero detector for the noise generator's log unit.
// Requests are arbitrated into a 2-stage pipeline that returns lz, normalized operand and owner ID.

module gng_lzd (
  input  logic [47:0] din,
  output logic [5:0]  lz
);

  logic [5:0]      grp_nz;
  logic [5:0][2:0] grp_lz;

  function automatic logic [2:0] lz8(input logic [7:0] b);
    logic [2:0] r;
    r = 3'd7;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = 3'(7 - i);
    end
    return r;
  endfunction

  always_comb begin
    grp_nz = '0;
    grp_lz = '0;
    for (int g = 0; g < 6; g++) begin
      grp_nz[g] = |din[8*g +: 8];
      grp_lz[g] = lz8(din[8*g +: 8]);
    end
  end

  // Highest non-empty byte group wins; an all-zero operand reports 48.
  always_comb begin
    lz = 6'd48;
    for (int g = 0; g < 6; g++) begin
      if (grp_nz[g]) lz = 6'((5 - g) * 8) + {3'b000, grp_lz[g]};
    end
  end

endmodule

module gng_lzd_arb #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [48*NREQ-1:0]     req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDW-1:0]         out_id,
  output logic [5:0]             out_lz,
  output logic [47:0]            out_norm,
  output logic                   out_zero
);

  localparam int IDW_EXP = (NREQ > 2) ? $clog2(NREQ) : 1;

  if ((NREQ < 2) || (NREQ > 8)) begin : g_bad_nreq
    $error("gng_lzd_arb: NREQ=%0d is outside 2..8", NREQ);
  end
  if (IDW != IDW_EXP) begin : g_bad_idw
    $error("gng_lzd_arb: IDW=%0d but NREQ=%0d needs %0d", IDW, NREQ, IDW_EXP);
  end

  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic            s1_vld_q, s1_vld_d;
  logic [47:0]     s1_op_q, s1_op_d;
  logic [IDW-1:0]  s1_id_q, s1_id_d;
  logic            s2_vld_q, s2_vld_d;
  logic [IDW-1:0]  s2_id_q, s2_id_d;
  logic [5:0]      s2_lz_q, s2_lz_d;
  logic [47:0]     s2_norm_q, s2_norm_d;
  logic            s2_zero_q, s2_zero_d;

  logic            s1_adv, s2_adv;
  logic [NREQ-1:0] pick_hi, pick_lo, gnt;
  logic [IDW-1:0]  id_hi, id_lo, gnt_id;
  logic            hit_hi, hit_lo, accept;
  logic [47:0]     sel_op;
  logic [5:0]      s1_lz;
  logic [47:0]     s1_norm;

  assign s2_adv = ~s2_vld_q | out_ready;
  assign s1_adv = ~s1_vld_q | s2_adv;

  // Two priority scans: requesters at or above the pointer first, then wrap to the lowest index.
  always_comb begin
    pick_hi = '0;
    pick_lo = '0;
    id_hi   = '0;
    id_lo   = '0;
    hit_hi  = 1'b0;
    hit_lo  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && !hit_lo) begin
        hit_lo     = 1'b1;
        pick_lo[i] = 1'b1;
        id_lo      = IDW'(i);
      end
      if (req_valid[i] && (IDW'(i) >= rr_ptr_q) && !hit_hi) begin
        hit_hi     = 1'b1;
        pick_hi[i] = 1'b1;
        id_hi      = IDW'(i);
      end
    end
    gnt    = hit_hi ? pick_hi : pick_lo;
    gnt_id = hit_hi ? id_hi : id_lo;
  end

  assign req_ready = (s1_adv && rstn) ? gnt : '0;
  assign accept    = |req_ready;

  always_comb begin
    sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) sel_op = req_data[48*i +: 48];
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
  end

  // Stage S1: granted operand and owner.
  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_op_d  = s1_op_q;
    s1_id_d  = s1_id_q;
    if (s1_adv) s1_vld_d = accept;
    if (accept) begin
      s1_op_d = sel_op;
      s1_id_d = gnt_id;
    end
  end

  gng_lzd u_lzd (
    .din (s1_op_q),
    .lz  (s1_lz)
  );

  assign s1_norm = s1_op_q << s1_lz;

  // Stage S2: result register feeding the output port.
  always_comb begin
    s2_vld_d  = s2_vld_q;
    s2_id_d   = s2_id_q;
    s2_lz_d   = s2_lz_q;
    s2_norm_d = s2_norm_q;
    s2_zero_d = s2_zero_q;
    if (s2_adv) s2_vld_d = s1_vld_q;
    if (s2_adv && s1_vld_q) begin
      s2_id_d   = s1_id_q;
      s2_lz_d   = s1_lz;
      s2_norm_d = s1_norm;
      s2_zero_d = (s1_lz == 6'd48);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_ptr_q <= '0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    s1_op_q   <= s1_op_d;
    s1_id_q   <= s1_id_d;
    s2_id_q   <= s2_id_d;
    s2_lz_q   <= s2_lz_d;
    s2_norm_q <= s2_norm_d;
    s2_zero_q <= s2_zero_d;
  end

  // Result fields read as zero whenever no result is held, so data flops need no reset.
  assign out_valid = s2_vld_q;
  assign out_id    = s2_vld_q ? s2_id_q : '0;
  assign out_lz    = s2_vld_q ? s2_lz_q : '0;
  assign out_norm  = s2_vld_q ? s2_norm_q : '0;
  assign out_zero  = s2_vld_q & s2_zero_q;

endmodule

// File: tb/tb_gng_lzd_arb.sv
// Bench for gng_lzd_arb: directed vectors on a 2-requester instance plus a 3-requester
// instance for pointer wrap, with a count-leading-zeros reference scoreboard.

module tb_gng_lzd_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;

  logic [1:0]   a_req_valid;
  logic [95:0]  a_req_data;
  logic [1:0]   a_req_ready;
  logic         a_out_valid, a_out_ready, a_out_zero;
  logic [0:0]   a_out_id;
  logic [5:0]   a_out_lz;
  logic [47:0]  a_out_norm;

  logic [2:0]   b_req_valid;
  logic [143:0] b_req_data;
  logic [2:0]   b_req_ready;
  logic         b_out_valid, b_out_ready, b_out_zero;
  logic [1:0]   b_out_id;
  logic [5:0]   b_out_lz;
  logic [47:0]  b_out_norm;

  gng_lzd_arb #(.NREQ(2), .IDW(1)) u_a (
    .clk(clk), .rstn(rstn), .req_valid(a_req_valid), .req_data(a_req_data),
    .req_ready(a_req_ready), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_id(a_out_id), .out_lz(a_out_lz), .out_norm(a_out_norm), .out_zero(a_out_zero)
  );

  gng_lzd_arb #(.NREQ(3), .IDW(2)) u_b (
    .clk(clk), .rstn(rstn), .req_valid(b_req_valid), .req_data(b_req_data),
    .req_ready(b_req_ready), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_id(b_out_id), .out_lz(b_out_lz), .out_norm(b_out_norm), .out_zero(b_out_zero)
  );

  typedef struct {
    int          id;
    logic [47:0] op;
  } exp_t;

  typedef struct {
    int          req;
    logic [47:0] op;
    int          lz;
    logic [47:0] norm;
    logic        zero;
  } vec_t;

  exp_t        sbq[$];
  exp_t        sbb[$];
  logic [47:0] q0[$];
  logic [47:0] q1[$];
  int          glog[$];
  int          rlog[$];
  int          blog[$];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic int clz_ref(input logic [47:0] v);
    for (int i = 47; i >= 0; i--) begin
      if (v[i]) return 47 - i;
    end
    return 48;
  endfunction

  task automatic drive_a();
    a_req_valid[0]     = (q0.size() != 0);
    a_req_valid[1]     = (q1.size() != 0);
    a_req_data[47:0]   = (q0.size() != 0) ? q0[0] : 48'h0;
    a_req_data[95:48]  = (q1.size() != 0) ? q1[0] : 48'h0;
  endtask

  task automatic check_out_a();
    exp_t        e;
    int          lz;
    logic [47:0] nrm;
    if (sbq.size() == 0) begin
      chk("a_unexpected_out", 64'(a_out_valid), 64'd0);
    end else begin
      e   = sbq.pop_front();
      lz  = clz_ref(e.op);
      nrm = e.op << lz;
      rlog.push_back(int'(a_out_id));
      chk("a_id", 64'(a_out_id), 64'(e.id));
      chk("a_lz", 64'(a_out_lz), 64'(lz));
      chk("a_norm", 64'(a_out_norm), 64'(nrm));
      chk("a_zero", 64'(a_out_zero), 64'(lz == 48));
    end
  endtask

  // One clock of DUT A: observe handshakes before the edge, update requesters after it.
  task automatic cyc_a();
    logic [1:0] acc;
    exp_t       e;
    #1;
    chk("a_ready_onehot0", 64'($onehot0(a_req_ready)), 64'd1);
    chk("a_ready_subset", 64'(a_req_ready & ~a_req_valid), 64'd0);
    if (a_out_valid && a_out_ready) check_out_a();
    acc = a_req_valid & a_req_ready;
    if (acc != 2'b00) begin
      e.id = acc[1] ? 1 : 0;
      e.op = a_req_data[48*e.id +: 48];
      sbq.push_back(e);
      glog.push_back(e.id);
    end
    @(posedge clk);
    @(negedge clk);
    if (acc[0]) void'(q0.pop_front());
    if (acc[1]) void'(q1.pop_front());
    drive_a();
  endtask

  task automatic cyc_b();
    logic [2:0]  acc;
    exp_t        e;
    int          lz;
    logic [47:0] nrm;
    #1;
    if (b_out_valid) begin
      if (sbb.size() == 0) begin
        chk("b_unexpected_out", 64'(b_out_valid), 64'd0);
      end else begin
        e   = sbb.pop_front();
        lz  = clz_ref(e.op);
        nrm = e.op << lz;
        blog.push_back(int'(b_out_id));
        chk("b_id", 64'(b_out_id), 64'(e.id));
        chk("b_lz", 64'(b_out_lz), 64'(lz));
        chk("b_norm", 64'(b_out_norm), 64'(nrm));
        chk("b_zero", 64'(b_out_zero), 64'(lz == 48));
      end
    end
    acc = b_req_valid & b_req_ready;
    if (acc != 3'b000) begin
      e.id = acc[2] ? 2 : (acc[1] ? 1 : 0);
      e.op = b_req_data[48*e.id +: 48];
      sbb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vt[8];
    int          g0, r0;
    logic [47:0] tmp;
    logic [0:0]  s_id;
    logic [5:0]  s_lz;
    logic [47:0] s_norm;
    logic        s_zero;

    vt[0] = '{0, 48'h0000_0001_0000, 31, 48'h8000_0000_0000, 1'b0};
    vt[1] = '{0, 48'h0000_0000_0000, 48, 48'h0000_0000_0000, 1'b1};
    vt[2] = '{1, 48'h8000_0000_0000,  0, 48'h8000_0000_0000, 1'b0};
    vt[3] = '{0, 48'h0000_0000_0001, 47, 48'h8000_0000_0000, 1'b0};
    vt[4] = '{1, 48'h0000_00FF_0000, 24, 48'hFF00_0000_0000, 1'b0};
    vt[5] = '{0, 48'h0123_4567_89AB,  7, 48'h91A2_B3C4_D580, 1'b0};
    vt[6] = '{1, 48'h7FFF_FFFF_FFFF,  1, 48'hFFFF_FFFF_FFFE, 1'b0};
    vt[7] = '{1, 48'h0000_0000_8000, 32, 48'h8000_0000_0000, 1'b0};

    rstn        = 1'b0;
    a_req_valid = '0;
    a_req_data  = '0;
    a_out_ready = 1'b0;
    b_req_valid = '0;
    b_req_data  = '0;
    b_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_req_ready", 64'(a_req_ready), 64'd0);
    chk("rst_out_id", 64'(a_out_id), 64'd0);
    chk("rst_out_lz", 64'(a_out_lz), 64'd0);
    chk("rst_out_norm", 64'(a_out_norm), 64'd0);
    chk("rst_out_zero", 64'(a_out_zero), 64'd0);
    chk("rst_b_out_valid", 64'(b_out_valid), 64'd0);
    rstn = 1'b1;

    // Single-operand vectors with hand-computed results and two-cycle latency.
    a_out_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      if (vt[v].req == 0) q0.push_back(vt[v].op);
      else                q1.push_back(vt[v].op);
      drive_a();
      cyc_a();
      chk("vec_lat_s1", 64'(a_out_valid), 64'd0);
      cyc_a();
      chk("vec_valid", 64'(a_out_valid), 64'd1);
      chk("vec_lz", 64'(a_out_lz), 64'(vt[v].lz));
      chk("vec_norm", 64'(a_out_norm), 64'(vt[v].norm));
      chk("vec_zero", 64'(a_out_zero), 64'(vt[v].zero));
      chk("vec_id", 64'(a_out_id), 64'(vt[v].req));
      cyc_a();
      chk("vec_drained", 64'(a_out_valid), 64'd0);
    end

    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    sbq.delete();

    // Both requesters continuously valid: alternating grants, one result per cycle.
    for (int k = 0; k < 4; k++) begin
      tmp = 48'h1 << (k * 7);
      q0.push_back(tmp);
      tmp = 48'h3 << (k * 9 + 2);
      q1.push_back(tmp);
    end
    g0 = glog.size();
    r0 = rlog.size();
    drive_a();
    repeat (10) cyc_a();
    chk("alt_grants", 64'(glog.size() - g0), 64'd8);
    chk("alt_results", 64'(rlog.size() - r0), 64'd8);
    for (int k = 0; k < glog.size() - g0; k++) chk("alt_grant_seq", 64'(glog[g0+k]), 64'(k % 2));
    for (int k = 0; k < rlog.size() - r0; k++) chk("alt_id_seq", 64'(rlog[r0+k]), 64'(k % 2));

    // Downstream stall for 5 cycles: two accepted, then ready drops and outputs hold.
    a_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tmp = 48'h0000_0100_0000 >> k;
      q0.push_back(tmp);
      tmp = 48'h0400_0000_0000 >> (k * 3);
      q1.push_back(tmp);
    end
    g0 = glog.size();
    r0 = rlog.size();
    drive_a();
    cyc_a();
    cyc_a();
    #1;
    chk("stall_valid", 64'(a_out_valid), 64'd1);
    s_id   = a_out_id;
    s_lz   = a_out_lz;
    s_norm = a_out_norm;
    s_zero = a_out_zero;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_ready", 64'(a_req_ready), 64'd0);
      chk("stall_hold_valid", 64'(a_out_valid), 64'd1);
      chk("stall_hold_id", 64'(a_out_id), 64'(s_id));
      chk("stall_hold_lz", 64'(a_out_lz), 64'(s_lz));
      chk("stall_hold_norm", 64'(a_out_norm), 64'(s_norm));
      chk("stall_hold_zero", 64'(a_out_zero), 64'(s_zero));
      cyc_a();
    end
    chk("stall_accepted", 64'(glog.size() - g0), 64'd2);
    a_out_ready = 1'b1;
    for (int k = 0; k < 30 && (q0.size() != 0 || q1.size() != 0 || sbq.size() != 0); k++) cyc_a();
    chk("stall_drained", 64'(sbq.size() + q0.size() + q1.size()), 64'd0);
    chk("stall_results", 64'(rlog.size() - r0), 64'd6);

    // Reset with both stages full discards them and restarts the pointer at 0.
    a_out_ready = 1'b0;
    q0.push_back(48'h0000_0F00_0000);
    q0.push_back(48'h0000_0000_0F00);
    g0 = glog.size();
    drive_a();
    cyc_a();
    cyc_a();
    cyc_a();
    #1;
    chk("prerst_full", 64'(a_out_valid), 64'd1);
    chk("prerst_grants", 64'(glog.size() - g0), 64'd2);
    q0.push_back(48'h0100_0000_0000);
    q1.push_back(48'h0000_0010_0000);
    rstn        = 1'b0;
    a_req_valid = 2'b00;
    #1;
    chk("inrst_ready", 64'(a_req_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    sbq.delete();
    #1;
    chk("postrst_valid", 64'(a_out_valid), 64'd0);
    chk("postrst_id", 64'(a_out_id), 64'd0);
    chk("postrst_lz", 64'(a_out_lz), 64'd0);
    chk("postrst_norm", 64'(a_out_norm), 64'd0);
    chk("postrst_zero", 64'(a_out_zero), 64'd0);
    chk("postrst_ready", 64'(a_req_ready), 64'd0);
    g0 = glog.size();
    r0 = rlog.size();
    drive_a();
    #1;
    chk("postrst_first_grant", 64'(a_req_ready), 64'd1);
    a_out_ready = 1'b1;
    for (int k = 0; k < 30 && (q0.size() != 0 || q1.size() != 0 || sbq.size() != 0); k++) cyc_a();
    chk("postrst_drained", 64'(sbq.size() + q0.size() + q1.size()), 64'd0);
    chk("postrst_results", 64'(rlog.size() - r0), 64'd2);
    if (glog.size() > g0) chk("postrst_grant0", 64'(glog[g0]), 64'd0);
    else                  chk("postrst_grant0_seen", 64'(glog.size() - g0), 64'd1);

    // Three requesters: move the pointer to 2, then 1 and 2 compete.
    b_out_ready         = 1'b1;
    b_req_valid         = 3'b010;
    b_req_data[95:48]   = 48'h0000_0000_00F0;
    #1;
    chk("rr3_grant_a", 64'(b_req_ready), 64'b010);
    cyc_b();
    b_req_valid         = 3'b110;
    b_req_data[95:48]   = 48'h0000_0000_0003;
    b_req_data[143:96]  = 48'h0000_4000_0000;
    #1;
    chk("rr3_grant_b", 64'(b_req_ready), 64'b100);
    cyc_b();
    b_req_data[143:96]  = 48'h0000_0000_0000;
    #1;
    chk("rr3_grant_c", 64'(b_req_ready), 64'b010);
    cyc_b();
    b_req_data[95:48]   = 48'h2000_0000_0000;
    #1;
    chk("rr3_grant_d", 64'(b_req_ready), 64'b100);
    cyc_b();
    b_req_valid = 3'b000;
    repeat (4) cyc_b();
    chk("rr3_drained", 64'(sbb.size()), 64'd0);
    chk("rr3_results", 64'(blog.size()), 64'd4);
    for (int k = 0; k < blog.size() && k < 4; k++) chk("rr3_id_seq", 64'(blog[k]), 64'((k % 2) + 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
